// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a debounced lock,
// releases downstream resets in order, and re-sequences or fails on lock trouble.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned NUM_DOMAINS   = 2,
    parameter int unsigned RELEASE_GAP   = 16
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic [NUM_DOMAINS-1:0]             domain_rst_n,
    output logic                               ready,
    output logic                               fail,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [7:0]                         loss_cnt
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_WAIT    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TMR_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(RELEASE_GAP + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_DOMAINS + 1);
    localparam int unsigned RTRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [HOLD_W-1:0]      HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]       TMR_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0]       STABLE_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]       GAP_LAST    = GAP_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [RTRY_W-1:0]      RETRY_LAST  = RTRY_W'(MAX_RETRIES - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE     = NUM_DOMAINS'(1);

    state_t              st;
    logic                sync1;
    logic                locked_s;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TMR_W-1:0]    timer;
    logic [STB_W-1:0]    stable;
    logic [GAP_W-1:0]    gap;
    logic [IDX_W-1:0]    idx;

    assign state = st;

    // pll_locked comes from the PLL's own domain; two flops before any decision.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st           <= S_HOLD;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            hold_cnt     <= '0;
            timer        <= '0;
            stable       <= '0;
            gap          <= '0;
            idx          <= '0;
            retry_cnt    <= '0;
            loss_cnt     <= '0;
        end else if (restart) begin
            st           <= S_HOLD;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            hold_cnt     <= '0;
            timer        <= '0;
            stable       <= '0;
            gap          <= '0;
            idx          <= '0;
            retry_cnt    <= '0;
        end else if ((st == S_RELEASE || st == S_RUN) && !locked_s) begin
            // Lock lost after release started: drop every domain at once and start over.
            st           <= S_HOLD;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            hold_cnt     <= '0;
            gap          <= '0;
            idx          <= '0;
            if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end else begin
            case (st)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        st       <= S_WAIT;
                        pll_rst  <= 1'b0;
                        hold_cnt <= '0;
                        timer    <= '0;
                        stable   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    timer  <= timer + 1'b1;
                    stable <= locked_s ? stable + 1'b1 : '0;
                    // A lock that becomes stable on the timeout cycle still counts.
                    if (locked_s && stable == STABLE_LAST) begin
                        st  <= S_RELEASE;
                        gap <= '0;
                        idx <= '0;
                    end else if (timer == TMR_LAST) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        pll_rst   <= 1'b1;
                        hold_cnt  <= '0;
                        if (retry_cnt == RETRY_LAST) begin
                            st   <= S_FAIL;
                            fail <= 1'b1;
                        end else begin
                            st <= S_HOLD;
                        end
                    end
                end
                S_RELEASE: begin
                    if (gap == GAP_LAST) begin
                        domain_rst_n <= domain_rst_n | (DOM_ONE << idx);
                        idx          <= idx + 1'b1;
                        gap          <= '0;
                        if (idx == IDX_LAST) begin
                            st        <= S_RUN;
                            ready     <= 1'b1;
                            retry_cnt <= '0;
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                S_RUN: begin
                end
                S_FAIL: begin
                end
                default: begin
                    st           <= S_HOLD;
                    pll_rst      <= 1'b1;
                    domain_rst_n <= '0;
                    ready        <= 1'b0;
                    fail         <= 1'b0;
                    hold_cnt     <= '0;
                end
            endcase
        end
    end

    // Released domains always form a contiguous run starting at bit 0.
    a_release_order: assert property (@(posedge refclk) disable iff (!rst_n)
        (((domain_rst_n + DOM_ONE) & domain_rst_n) == '0));

    a_ready_all_released: assert property (@(posedge refclk) disable iff (!rst_n)
        (ready |-> (&domain_rst_n)));

    a_pll_rst_decode: assert property (@(posedge refclk) disable iff (!rst_n)
        (pll_rst == (st == S_HOLD || st == S_FAIL)));

endmodule
